// File: rtl/dispense_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : dispense_cmd_initiator
// Description : Queues candy orders in a small FIFO and issues each one to the
//               dispenser with a four-phase handshake:
//               amount setup -> candyflag high -> ack high -> candyflag low
//               -> ack low.
//               The optional handshake timeout is compiled in with the macro
//               DISPENSE_CMD_TIMEOUT_EN. Without it the FSM waits forever for
//               the acknowledge, err_timeout is tied low and err_clr is ignored.
// Ports       : clk_x1       in   12 MHz system clock (rising edge)
//               rstn         in   synchronous active-low reset
//               order_valid  in   order push strobe
//               order_amount in   [1:0] candy amount code of the order
//               order_ready  out  FIFO can accept a push (low in reset)
//               handshake    in   asynchronous acknowledge from dispenser
//               candyflag    out  dispense request to the dispenser
//               stateamount  out  [1:0] amount presented to the dispenser
//               busy         out  FSM is not in IDLE
//               done_pulse   out  one-cycle pulse when a transfer completes
//               fifo_count   out  [4:0] number of queued orders
//               err_timeout  out  sticky handshake timeout flag
//               err_clr      in   clears err_timeout and leaves ERR
// Revision    : 1.0 - initial release
// ============================================================================
module dispense_cmd_initiator #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic       clk_x1,
    input  logic       rstn,
    input  logic       order_valid,
    input  logic [1:0] order_amount,
    output logic       order_ready,
    input  logic       handshake,
    output logic       candyflag,
    output logic [1:0] stateamount,
    output logic       busy,
    output logic       done_pulse,
    output logic [4:0] fifo_count,
    output logic       err_timeout,
    input  logic       err_clr
);

    localparam int         ADDR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] FULL_COUNT = 5'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

    logic [2:0]        state;
    logic [2:0]        next_state;

    // ------------------------------------------------------------------------
    // Order FIFO
    // ------------------------------------------------------------------------
    logic [1:0]        fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [4:0]        count;
    logic              push;
    logic              pop;

    // Gating with rstn keeps the upstream from believing a push landed while
    // the FIFO is being flushed.
    assign order_ready = rstn && (count != FULL_COUNT);
    assign push        = order_valid && order_ready;
    assign pop         = (state == ST_IDLE) && (count != 5'd0);
    assign fifo_count  = count;

    always_ff @(posedge clk_x1) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: emptiness is defined by the pointers/count.
    always_ff @(posedge clk_x1) begin
        if (push) begin
            fifo_mem[wr_ptr] <= order_amount;
        end
    end

    // ------------------------------------------------------------------------
    // Acknowledge synchronizer
    // ------------------------------------------------------------------------
    logic hs_meta;
    logic hs_s;

    always_ff @(posedge clk_x1) begin
        if (!rstn) begin
            hs_meta <= 1'b0;
            hs_s    <= 1'b0;
        end else begin
            hs_meta <= handshake;
            hs_s    <= hs_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Handshake timeout
    // ------------------------------------------------------------------------
    logic tmo_hit;

`ifdef DISPENSE_CMD_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic        err_flag;

    assign tmo_hit = ((state == ST_REQ) || (state == ST_RELEASE)) &&
                     (tmo_cnt == (TIMEOUT_CYCLES - 24'd1));
    assign err_timeout = err_flag;

    // Each waiting phase (REQ, RELEASE) gets its own full budget: the counter
    // restarts on every entry into either state.
    always_ff @(posedge clk_x1) begin
        if (!rstn) begin
            tmo_cnt  <= 24'd0;
            err_flag <= 1'b0;
        end else begin
            if (((next_state == ST_REQ) || (next_state == ST_RELEASE)) &&
                (next_state != state)) begin
                tmo_cnt <= 24'd0;
            end else if ((state == ST_REQ) || (state == ST_RELEASE)) begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end

            if ((next_state == ST_ERR) && (state != ST_ERR)) begin
                err_flag <= 1'b1;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_cfg  = err_clr ^ (^TIMEOUT_CYCLES);
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_x1) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                next_state = ST_REQ;
            end
            ST_REQ: begin
                // A stale ack already high on entry still advances normally.
                if (hs_s) begin
                    next_state = ST_RELEASE;
                end else if (tmo_hit) begin
                    next_state = ST_ERR;
                end
            end
            ST_RELEASE: begin
                if (!hs_s) begin
                    next_state = ST_IDLE;
                end else if (tmo_hit) begin
                    next_state = ST_ERR;
                end
            end
            ST_ERR: begin
`ifdef DISPENSE_CMD_TIMEOUT_EN
                if (err_clr) begin
                    next_state = ST_IDLE;
                end
`else
                next_state = ST_IDLE;
`endif
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // Decoded straight from the state register so that a reset edge drops the
    // request on that same edge.
    always_comb begin
        candyflag = (state == ST_REQ);
        busy      = (state != ST_IDLE);
    end

    // Amount is captured on the pop edge and held until the next pop, which
    // gives the dispenser one SETUP cycle of stable amount before the flag.
    always_ff @(posedge clk_x1) begin
        if (!rstn) begin
            stateamount <= 2'd0;
            done_pulse  <= 1'b0;
        end else begin
            if (pop) begin
                stateamount <= fifo_mem[rd_ptr];
            end
            done_pulse <= (state == ST_RELEASE) && (next_state == ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispense_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispense_cmd_initiator
// Description : Directed, self-checking bench for dispense_cmd_initiator.
//               Expected amounts are queued when orders are pushed and popped
//               when the DUT raises candyflag. A behavioural dispenser drives
//               the handshake pin. Build with DISPENSE_CMD_TIMEOUT_EN defined
//               to exercise the timeout/ERR path instead of the endless wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispense_cmd_initiator;

    logic       clk_x1 = 1'b0;
    logic       rstn = 1'b0;
    logic       order_valid = 1'b0;
    logic [1:0] order_amount = 2'd0;
    logic       handshake = 1'b0;
    logic       err_clr = 1'b0;
    logic       order_ready;
    logic       candyflag;
    logic [1:0] stateamount;
    logic       busy;
    logic       done_pulse;
    logic [4:0] fifo_count;
    logic       err_timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    // dispenser model: 0 = never ack, 1 = ack 10 after flag / release 5 after
    // flag drop, 2 = ack mirrors flag immediately
    int mode        = 0;
    int hi_cnt      = 0;
    int lo_cnt      = 0;
    int hs_rise_cyc = -100;
    int fall_cyc    = -100;
    int done_cnt    = 0;
    int d0          = 0;
    int rcyc        = 0;
    int bad         = 0;

    logic       prev_flag   = 1'b0;
    logic       prev_busy   = 1'b0;
    logic [1:0] prev_amount = 2'd0;
    logic [1:0] exp_q[$];
    logic [1:0] amts [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};

    always #5 clk_x1 = ~clk_x1;

    dispense_cmd_initiator #(
        .TIMEOUT_CYCLES (24'd16),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_x1       (clk_x1),
        .rstn         (rstn),
        .order_valid  (order_valid),
        .order_amount (order_amount),
        .order_ready  (order_ready),
        .handshake    (handshake),
        .candyflag    (candyflag),
        .stateamount  (stateamount),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .fifo_count   (fifo_count),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge, run the scoreboard, then
    // let the dispenser model react.
    task automatic tick();
        logic [1:0] e;
        @(posedge clk_x1);
        #1;
        cyc++;
        if (candyflag === 1'b1 && prev_flag === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_flag", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("flag_amount", stateamount, e);
                check("amount_setup_before_flag", prev_amount, e);
                check("setup_cycle_before_flag", prev_busy, 1);
                check("flag_gap_ge2", (cyc - fall_cyc) >= 2, 1);
            end
        end
        if (candyflag === 1'b0 && prev_flag === 1'b1) begin
            if (mode == 1) begin
                check("hs_rise_to_flag_fall", cyc - hs_rise_cyc, 3);
            end
            fall_cyc = cyc;
        end
        if (done_pulse === 1'b1) begin
            done_cnt++;
        end
        case (mode)
            1: begin
                if (candyflag) begin
                    hi_cnt++;
                    lo_cnt = 0;
                    if (hi_cnt == 10 && !handshake) begin
                        handshake   = 1'b1;
                        hs_rise_cyc = cyc;
                    end
                end else if (handshake) begin
                    lo_cnt++;
                    if (lo_cnt == 5) begin
                        handshake = 1'b0;
                        hi_cnt    = 0;
                    end
                end
            end
            2:       handshake = candyflag;
            default: handshake = 1'b0;
        endcase
        prev_flag   = candyflag;
        prev_busy   = busy;
        prev_amount = stateamount;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, done_cnt, target);
    endtask

    task automatic wait_flag(input int budget, input string tag);
        int n = 0;
        while (candyflag !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, candyflag, 1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_candyflag", candyflag, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_pulse, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_stateamount", stateamount, 0);
        check("rst_err", err_timeout, 0);
        check("rst_order_ready", order_ready, 0);
        rstn = 1'b1;
        tick();
        check("post_rst_ready", order_ready, 1);

        // ---------------- single transfer, delayed dispenser ----------------
        mode = 1;
        exp_q.push_back(2'd2);
        order_valid = 1'b1; order_amount = 2'd2;
        tick();
        order_valid = 1'b0;
        check("t1_count_after_push", fifo_count, 1);
        d0 = done_cnt;
        wait_done(d0 + 1, 200, "t1_done");
        check("t1_count_zero", fifo_count, 0);
        repeat (5) tick();
        check("t1_single_done", done_cnt, d0 + 1);
        check("t1_idle", busy, 0);

        // ---------------- FIFO full / drop ----------------
        mode = 0;
        exp_q.push_back(2'd3);
        order_valid = 1'b1; order_amount = 2'd3;
        tick();
        order_valid = 1'b0;
        wait_flag(10, "t2_blocker_req");
        for (int i = 0; i < 5; i++) begin
            order_valid  = 1'b1;
            order_amount = amts[i];
            if (i < 4) exp_q.push_back(amts[i]);
            tick();
            check("t2_count", fifo_count, (i < 4) ? i + 1 : 4);
            check("t2_ready", order_ready, (i < 3) ? 1 : 0);
        end
        order_valid = 1'b0;
        check("t2_flag_held", candyflag, 1);
        mode = 2;
        d0 = done_cnt;
        wait_done(d0 + 1, 50, "t2_blocker_done");
        check("t2_count_before_pop", fifo_count, 4);
        tick();
        check("t2_count_after_pop", fifo_count, 3);
        wait_done(d0 + 5, 400, "t2_drain");
        check("t2_sb_empty", exp_q.size(), 0);

        // ---------------- two orders, immediate ack ----------------
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        d0 = done_cnt;
        order_valid = 1'b1; order_amount = 2'd1;
        tick();
        order_amount = 2'd3;
        tick();
        order_valid = 1'b0;
        wait_done(d0 + 2, 200, "t3_two_done");
        check("t3_sb_empty", exp_q.size(), 0);

        // ---------------- reset while in REQ ----------------
        mode = 0;
        d0 = done_cnt;
        exp_q.push_back(2'd2);
        order_valid = 1'b1; order_amount = 2'd2;
        tick();
        order_amount = 2'd1;
        tick();
        order_amount = 2'd0;
        tick();
        order_valid = 1'b0;
        check("t4_in_req", candyflag, 1);
        check("t4_queued", fifo_count, 2);
        rstn = 1'b0;
        tick();
        check("t4_flag_dropped", candyflag, 0);
        check("t4_fifo_flushed", fifo_count, 0);
        check("t4_not_busy", busy, 0);
        check("t4_no_done", done_pulse, 0);
        check("t4_amount_cleared", stateamount, 0);
        check("t4_ready_in_reset", order_ready, 0);
        rstn = 1'b1;
        repeat (5) tick();
        check("t4_stays_idle", busy, 0);
        check("t4_done_count", done_cnt, d0);
        check("t4_sb_empty", exp_q.size(), 0);

        // ---------------- never-ack behaviour ----------------
        mode = 0;
        d0 = done_cnt;
`ifdef DISPENSE_CMD_TIMEOUT_EN
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        order_valid = 1'b1; order_amount = 2'd2;
        tick();
        order_amount = 2'd1;
        tick();
        order_valid = 1'b0;
        wait_flag(10, "t5_req");
        rcyc = cyc;
        for (int n = 0; n < 40 && err_timeout !== 1'b1; n++) tick();
        check("t5_err_after_16", cyc - rcyc, 16);
        check("t5_err_set", err_timeout, 1);
        check("t5_flag_low", candyflag, 0);
        check("t5_busy_err", busy, 1);
        repeat (3) tick();
        check("t5_err_sticky", err_timeout, 1);
        check("t5_queue_retained", fifo_count, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_err_cleared", err_timeout, 0);
        check("t5_back_idle", busy, 0);
        mode = 2;
        wait_done(d0 + 1, 100, "t5_next_order_done");
        check("t5_sb_empty", exp_q.size(), 0);
`else
        exp_q.push_back(2'd2);
        order_valid = 1'b1; order_amount = 2'd2;
        tick();
        order_valid = 1'b0;
        wait_flag(10, "t5_req");
        bad = 0;
        repeat (1000) begin
            tick();
            if (candyflag !== 1'b1 || err_timeout !== 1'b0) bad++;
        end
        check("t5_flag_held_1000", bad, 0);
        check("t5_err_tied_low", err_timeout, 0);
        mode = 2;
        wait_done(d0 + 1, 100, "t5_late_ack_done");
        check("t5_sb_empty", exp_q.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dispense_cmd_initiator.md
DISPENSE_CMD_INITIATOR -- requirements
Module: dispense_cmd_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd12_000_000, handshake wait limit in clk_x1 cycles (1 s at 12 MHz).
REQ-002 Parameter FIFO_DEPTH, default 4, number of queued orders; SHALL be a power of two, 2..16.
REQ-003 clk_x1  in  1  single 12 MHz system clock; all logic SHALL be on its rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 order_valid  in  1  order push strobe.
REQ-006 order_amount  in  2  candy amount code for the order (0..3).
REQ-007 order_ready  out  1  high when the order FIFO can accept a push (not full).
REQ-008 handshake  in  1  asynchronous acknowledge from the dispenser.
REQ-009 candyflag  out  1  dispense request to the dispenser.
REQ-010 stateamount  out  2  amount presented to the dispenser; [0] drives stateamount0, [1] drives stateamount1.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 done_pulse  out  1  one-cycle pulse on completion of a four-phase transfer.
REQ-013 fifo_count  out  5  number of orders held, 0..FIFO_DEPTH.
REQ-014 err_timeout  out  1  sticky timeout flag.
REQ-015 err_clr  in  1  clears err_timeout and leaves ERR.

Function
REQ-016 Push rule: an order SHALL be written when order_valid && order_ready. A push while full SHALL be dropped and leave the FIFO unchanged.
REQ-017 Pop rule: IDLE SHALL pop the head entry when fifo_count>0. A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-018 handshake SHALL pass through a 2-flop synchronizer; hs_s denotes the synchronized value, which lags the pin by 2 cycles.
REQ-019 FSM states SHALL be IDLE, SETUP, REQ, RELEASE, ERR.
REQ-020 IDLE -> SETUP on pop; the popped amount SHALL be registered onto stateamount in the same edge.
REQ-021 In SETUP, candyflag SHALL be 0 for exactly 1 cycle, giving amount setup before the flag; the FSM then goes to REQ.
REQ-022 In REQ, candyflag SHALL be 1. Transition to RELEASE on the first edge with hs_s=1.
REQ-023 In RELEASE, candyflag SHALL be 0. On hs_s=0 the FSM SHALL go to IDLE and pulse done_pulse in that cycle.
REQ-024 stateamount SHALL hold its value from SETUP through the end of RELEASE, and hold its last value in IDLE.
REQ-025 Latency: the handshake pin rising SHALL cause candyflag to fall 3 edges later.
REQ-026 Minimum gap between consecutive candyflag pulses SHALL be 2 cycles (IDLE + SETUP).
REQ-027 If hs_s=1 on entry to REQ (stale acknowledge), the FSM SHALL still go to RELEASE and complete normally.

Reset
REQ-028 On a clk_x1 edge with rstn=0, the following SHALL be forced: FSM=IDLE, FIFO empty, fifo_count=0, candyflag=0, stateamount=0, busy=0, done_pulse=0, err_timeout=0, synchronizer flops=0, timeout counter=0.
REQ-029 Reset mid-transfer SHALL drop candyflag on that same edge and discard the in-flight order and all queued orders.
REQ-030 order_ready SHALL be 0 while rstn=0.

Configuration
REQ-031 Macro DISPENSE_CMD_TIMEOUT_EN SHALL compile the handshake timeout in or out.
REQ-032 Defined: a 24-bit counter SHALL clear on entry to REQ or RELEASE and increment each cycle in those states. Reaching TIMEOUT_CYCLES-1 SHALL go to ERR, set err_timeout, force candyflag=0, and discard the in-flight order.
REQ-033 Defined: ERR SHALL not pop. err_clr SHALL clear err_timeout and return to IDLE on the next edge. Queued orders SHALL be retained.
REQ-034 Not defined: no counter and no ERR entry; err_timeout SHALL be tied 0, err_clr ignored, and the FSM waits indefinitely.

Verification
REQ-035 Push amount=2, dispenser model raises handshake 10 cycles after candyflag and lowers it 5 cycles after flag drop -> stateamount=2 one cycle before candyflag=1; candyflag falls 3 cycles after handshake rises; one done_pulse; fifo_count back to 0.
REQ-036 With handshake held 0, push 5 orders back-to-back (amounts 0,1,2,3,1) -> order_ready=0 after the 4th stored order; the 5th is dropped; fifo_count=4 then 3 after the first pop.
REQ-037 Queue amounts 1,3 with an immediate-ack model -> two flag pulses in order 1 then 3, gap >= 2 cycles, two done_pulses.
REQ-038 Assert rstn=0 while in REQ with 2 orders queued -> next edge candyflag=0, fifo_count=0, busy=0, and no done_pulse.
REQ-039 With DISPENSE_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack -> ERR after 16 REQ cycles with err_timeout=1 and candyflag=0; err_clr -> IDLE, and the next queued order is issued.
REQ-040 Without the macro, same stimulus -> candyflag stays 1 for 1000 cycles and err_timeout stays 0.
